// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM state encodings for the logic operation arbiter.
package logic_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Shared bitwise datapath: AND / OR / XOR, reserved opcode yields zero and bad_op.
// Latency: purely combinational.
// Backpressure: none, evaluates every cycle.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             bad_op
);

    always_comb begin
        y      = '0;
        bad_op = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: bad_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Time-shares one logic_unit among NREQ requesters; LOGIC_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: grant 1 cycle after req is sampled, done/result 2 cycles after, 3-cycle service per operation.
// Backpressure: requesters hold req until their done pulse; non-granted requests wait for the next IDLE cycle.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] a,
    input  logic [WIDTH*NREQ-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  err,
    output logic                  busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   pick;
    logic              take;
    logic [NREQ-1:0]   gnt_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  y;
    logic              bad_op;
    logic [WIDTH-1:0]  result_q;
    logic              err_q;

    assign take = (state == ST_IDLE) && (|req);

`ifdef LOGIC_ARB_RR_EN
    logic [IDXW-1:0] last_gnt;
    logic [IDXW-1:0] cand;
    logic            found;

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDXW'((int'(last_gnt) + k) % NREQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= IDXW'(NREQ - 1);
        end else if (take) begin
            last_gnt <= pick;
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) pick = IDXW'(k);
        end
    end
`endif

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .y      (y),
        .bad_op (bad_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|req) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands are captured at the grant edge; the requester's inputs are ignored afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (take) begin
                gnt_q <= NREQ'(1) << pick;
                op_q  <= op[2*pick +: 2];
                a_q   <= a[WIDTH*pick +: WIDTH];
                b_q   <= b[WIDTH*pick +: WIDTH];
            end
            if (state == ST_EXEC) begin
                result_q <= y;
            end
            err_q <= (state == ST_EXEC) && bad_op;
        end
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        gnt    = busy ? gnt_q : '0;
        done   = (state == ST_DONE) ? gnt_q : '0;
        result = result_q;
        err    = err_q;
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Randomized and directed bench for logic_op_arbiter against a transaction-timeline reference model.
module tb_logic_op_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] a;
    logic [WIDTH*NREQ-1:0] b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  err;
    logic                  busy;

    always #5 clk = ~clk;

    logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .op     (op),
        .a      (a),
        .b      (b),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .err    (err),
        .busy   (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: a grant sampled at edge g owns cycles g+1 (exec) and g+2 (done).
    int              edge_n = 0;
    int              g_edge = -100;
    int              win    = 0;
    int              m_last = NREQ - 1;
    logic [1:0]      m_op   = 2'b00;
    logic [7:0]      m_a    = 8'h00;
    logic [7:0]      m_b    = 8'h00;
    logic [7:0]      m_res  = 8'h00;
    logic            m_bad  = 1'b0;

    function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int pick_winner(input logic [NREQ-1:0] r, input int last);
`ifdef LOGIC_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    always @(negedge rst_n) begin
        g_edge = -100;
        m_res  = 8'h00;
        m_bad  = 1'b0;
        m_last = NREQ - 1;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (edge_n == g_edge + 1) begin
                m_res = ref_op(m_op, m_a, m_b);
                m_bad = (m_op == 2'b11);
            end
            if (edge_n >= g_edge + 3 && (|req)) begin
                win    = pick_winner(req, m_last);
                g_edge = edge_n;
                m_op   = op[2*win +: 2];
                m_a    = a[8*win +: 8];
                m_b    = b[8*win +: 8];
                m_last = win;
            end
            edge_n++;
        end
    end

    int              mon_e;
    logic            mon_act;
    logic            mon_fin;
    logic [NREQ-1:0] mon_oh;

    always @(negedge clk) begin
        mon_e   = edge_n - 1;
        mon_act = (mon_e == g_edge) || (mon_e == g_edge + 1);
        mon_fin = (mon_e == g_edge + 1);
        mon_oh  = NREQ'(1) << win;
        chk("busy",   busy,   mon_act);
        chk("gnt",    gnt,    mon_act ? mon_oh : '0);
        chk("done",   done,   mon_fin ? mon_oh : '0);
        chk("err",    err,    mon_fin && m_bad);
        chk("result", result, m_res);
    end

    logic [NREQ-1:0] pend = '0;
    int              done_log[$];

    task automatic set_lane(input int i, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        op[2*i +: 2] = o;
        a[8*i +: 8]  = x;
        b[8*i +: 8]  = y;
    endtask

    // One negedge of requester behaviour: drop on done, re-request with probability pct.
    task automatic lane_step(input int pct);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                if (done[i]) begin
                    req[i]  = 1'b0;
                    pend[i] = 1'b0;
                    done_log.push_back(i);
                end else if (gnt[i] && $urandom_range(0, 3) == 0) begin
                    set_lane(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                end
            end else if (int'($urandom_range(1, 100)) <= pct) begin
                set_lane(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                req[i]  = 1'b1;
                pend[i] = 1'b1;
            end
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && pend != '0; t++) begin
            @(negedge clk);
            lane_step(0);
        end
        chk("drain", pend, '0);
    endtask

    task automatic wait_bit(input logic is_done, input int i, output int t);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(is_done ? done[i] : gnt[i]) && t < 20);
    endtask

    task automatic do_op(input string tag, input int i, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] er, input logic ee);
        int t;
        set_lane(i, o, x, y);
        req[i] = 1'b1;
        wait_bit(1'b1, i, t);
        chk({tag, "_lat"}, t, 2);
        chk({tag, "_res"}, result, er);
        chk({tag, "_err"}, err, ee);
        req[i] = 1'b0;
        @(negedge clk);
    endtask

    int t;

    initial begin
        req = '0; op = '0; a = '0; b = '0;
        rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // All requesters continuously active.
        done_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            set_lane(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            req[i]  = 1'b1;
            pend[i] = 1'b1;
        end
        for (int k = 0; k < 200 && done_log.size() < 12; k++) begin
            @(negedge clk);
            lane_step(100);
        end
        chk("order_cnt", done_log.size(), 12);
        for (int k = 0; k < done_log.size() && k < 12; k++) begin
`ifdef LOGIC_ARB_RR_EN
            chk("order", done_log[k], k % NREQ);
`else
            chk("order", done_log[k], 0);
`endif
        end
        drain();
        repeat (2) @(negedge clk);

        do_op("single", 0, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0);
        do_op("and",    2, 2'b00, 8'hAA, 8'h0F, 8'h0A, 1'b0);
        do_op("or",     2, 2'b01, 8'hAA, 8'h0F, 8'hAF, 1'b0);
        do_op("xor",    2, 2'b10, 8'hAA, 8'h0F, 8'hA5, 1'b0);
        do_op("rsvd",   2, 2'b11, 8'hAA, 8'h0F, 8'h00, 1'b1);

        // Late request during another grant; granted requester's operands change after grant.
        set_lane(1, 2'b01, 8'h12, 8'h30);
        req[1] = 1'b1;
        wait_bit(1'b0, 1, t);
        set_lane(3, 2'b10, 8'h55, 8'hFF);
        req[3] = 1'b1;
        set_lane(1, 2'b00, 8'h00, 8'h00);
        wait_bit(1'b1, 1, t);
        chk("sim_res1", result, 8'h32);
        req[1] = 1'b0;
        wait_bit(1'b1, 3, t);
        chk("sim_lat3", t, 3);
        chk("sim_res3", result, 8'hAA);
        req[3] = 1'b0;
        @(negedge clk);

        // Reset during requester 2's exec cycle.
        set_lane(2, 2'b10, 8'h3C, 8'h0F);
        req[2] = 1'b1;
        wait_bit(1'b0, 2, t);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_gnt", gnt, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_result", result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_bit(1'b1, 2, t);
        chk("arst_lat", t, 2);
        chk("arst_res", result, 8'h33);
        req[2] = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_res", result, 8'h33);
        end

        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            lane_step(30);
        end
        drain();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
